// File: rtl/in_flight_arbiter.sv
// Round-robin request arbiter with per-colour in-flight accounting.
// Each colour owns MIN_DEPTH reserved slots; the remainder is a shared pool.
module in_flight_arbiter #(
    parameter int COLORS    = 4,
    parameter int MIN_DEPTH = 32,
    parameter int MAX_DEPTH = 512
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [COLORS-1:0]              req,
    output logic [COLORS-1:0]              grant,
    output logic                           issue_valid,
    output logic [$clog2(COLORS)-1:0]      issue_tag,
    input  logic                           issue_ready,
    input  logic                           ret_valid,
    input  logic [$clog2(COLORS)-1:0]      ret_tag,
    output logic [$clog2(MAX_DEPTH):0]     total,
    output logic                           underflow
);

    localparam int TW        = $clog2(COLORS);
    localparam int CW        = $clog2(MAX_DEPTH) + 1;
    localparam int HEAD_ROOM = MAX_DEPTH - COLORS * MIN_DEPTH;
    localparam logic [CW-1:0] MIN_C = CW'(MIN_DEPTH);
    localparam logic [CW-1:0] HR_C  = CW'(HEAD_ROOM);
    localparam logic [CW-1:0] ONE_C = CW'(1);
    localparam logic [TW-1:0] ONE_T = TW'(1);

    logic [CW-1:0]     cnt [COLORS];
    logic [CW-1:0]     shared;
    logic [TW-1:0]     rr_ptr;

    logic [COLORS-1:0] eligible;
    logic              slot_free;
    logic              win_found;
    logic [TW-1:0]     win_idx;
    logic [TW-1:0]     scan_idx;
    logic [COLORS-1:0] win_onehot;
    logic              push;
    logic              pop_ok;
    logic              sh_inc;
    logic              sh_dec;

    assign slot_free = !issue_valid || issue_ready;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < COLORS; i++) begin
            eligible[i] = req[i] && ((cnt[i] < MIN_C) || (shared < HR_C));
        end
    end

    // Scan from rr_ptr upward; the index wraps naturally because COLORS is a power of 2.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int k = 0; k < COLORS; k++) begin
            scan_idx = rr_ptr + TW'(k);
            if (!win_found && eligible[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        win_onehot          = '0;
        win_onehot[win_idx] = 1'b1;
    end

    assign push   = !rst && slot_free && win_found;
    assign grant  = push ? win_onehot : '0;
    assign pop_ok = ret_valid && (cnt[ret_tag] != '0);

    // Same-colour push+pop cancels, so neither touches the shared pool.
    assign sh_inc = push && (cnt[win_idx] >= MIN_C) && !(pop_ok && (ret_tag == win_idx));
    assign sh_dec = pop_ok && (cnt[ret_tag] > MIN_C) && !(push && (ret_tag == win_idx));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < COLORS; i++) begin
                cnt[i] <= '0;
            end
            shared      <= '0;
            total       <= '0;
            rr_ptr      <= '0;
            issue_valid <= 1'b0;
            issue_tag   <= '0;
            underflow   <= 1'b0;
        end else begin
            for (int i = 0; i < COLORS; i++) begin
                if (push && (win_idx == TW'(i)) && !(pop_ok && (ret_tag == TW'(i)))) begin
                    cnt[i] <= cnt[i] + ONE_C;
                end else if (pop_ok && (ret_tag == TW'(i)) && !(push && (win_idx == TW'(i)))) begin
                    cnt[i] <= cnt[i] - ONE_C;
                end
            end

            case ({sh_inc, sh_dec})
                2'b10:   shared <= shared + ONE_C;
                2'b01:   shared <= shared - ONE_C;
                default: shared <= shared;
            endcase

            case ({push, pop_ok})
                2'b10:   total <= total + ONE_C;
                2'b01:   total <= total - ONE_C;
                default: total <= total;
            endcase

            if (slot_free) begin
                issue_valid <= win_found;
                if (win_found) begin
                    issue_tag <= win_idx;
                    rr_ptr    <= win_idx + ONE_T;
                end
            end

            if (ret_valid && (cnt[ret_tag] == '0)) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_in_flight_arbiter.sv
// Bench for in_flight_arbiter (2 colours, 2 reserved each, capacity 6) against an
// integer-count reference model of the admission and round-robin rules.
module tb_in_flight_arbiter;

    localparam int C  = 2;
    localparam int MN = 2;
    localparam int MX = 6;
    localparam int HR = MX - C * MN;

    logic       clk;
    logic       rst;
    logic [1:0] req;
    logic [1:0] grant;
    logic       issue_valid;
    logic [0:0] issue_tag;
    logic       issue_ready;
    logic       ret_valid;
    logic [0:0] ret_tag;
    logic [3:0] total;
    logic       underflow;

    in_flight_arbiter #(.COLORS(C), .MIN_DEPTH(MN), .MAX_DEPTH(MX)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .grant       (grant),
        .issue_valid (issue_valid),
        .issue_tag   (issue_tag),
        .issue_ready (issue_ready),
        .ret_valid   (ret_valid),
        .ret_tag     (ret_tag),
        .total       (total),
        .underflow   (underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    int m_cnt [C];
    int m_ptr;
    bit m_iv;
    int m_tag;
    bit m_uf;

    logic [1:0] obs_grant, exp_grant;
    logic       obs_iv, exp_iv, obs_uf, exp_uf;
    logic [0:0] obs_tag, exp_tag;
    logic [3:0] obs_total, exp_total;

    function automatic int m_shared();
        int s = 0;
        for (int i = 0; i < C; i++) s += (m_cnt[i] > MN) ? m_cnt[i] - MN : 0;
        return s;
    endfunction

    function automatic int m_sum();
        int s = 0;
        for (int i = 0; i < C; i++) s += m_cnt[i];
        return s;
    endfunction

    // One clock: drive inputs, sample grant, advance model and DUT, sample outputs.
    task automatic cycle(input logic [1:0] r, input logic rdy, input logic rv,
                         input logic rt, input logic rs);
        int  w;
        bit  slot, pop_ok;
        req = r; issue_ready = rdy; ret_valid = rv; ret_tag = rt; rst = rs;
        #1;
        obs_grant = grant;
        w = -1;
        if (rs) begin
            for (int i = 0; i < C; i++) m_cnt[i] = 0;
            m_ptr = 0; m_iv = 0; m_tag = 0; m_uf = 0;
        end else begin
            slot = !m_iv || rdy;
            if (slot) begin
                for (int k = 0; k < C; k++) begin
                    int idx = (m_ptr + k) % C;
                    if (w < 0 && r[idx] && (m_cnt[idx] < MN || m_shared() < HR)) w = idx;
                end
            end
            pop_ok = rv && (m_cnt[int'(rt)] > 0);
            if (rv && m_cnt[int'(rt)] == 0) m_uf = 1;
            if (w >= 0) m_cnt[w]++;
            if (pop_ok) m_cnt[int'(rt)]--;
            if (slot) begin
                m_iv = (w >= 0);
                if (w >= 0) begin
                    m_tag = w;
                    m_ptr = (w + 1) % C;
                end
            end
        end
        exp_grant = (w >= 0) ? 2'(1 << w) : 2'b00;
        @(posedge clk);
        #1;
        obs_iv = issue_valid; obs_tag = issue_tag; obs_total = total; obs_uf = underflow;
        exp_iv = m_iv; exp_tag = 1'(m_tag); exp_total = 4'(m_sum()); exp_uf = m_uf;
    endtask

    task automatic apply_reset();
        cycle(2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        logic [1:0] r;
        for (int i = 0; i < 2; i++) begin
            cycle(2'b11, 1'b1, 1'b0, 1'b0, 1'b1);
            n_checks++;
            if (obs_grant !== 2'b00 || obs_iv !== 1'b0 || obs_total !== 4'd0 || obs_uf !== 1'b0 || obs_tag !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_state: grant=%b iv=%b tag=%b total=%0d uf=%b, want all zero",
                         obs_grant, obs_iv, obs_tag, obs_total, obs_uf);
            end
        end
        r = 2'b11;
        cycle(r, 1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (obs_grant !== 2'b01) begin
            n_errors++;
            $display("FAIL first_grant: got %b want 01", obs_grant);
        end
    endtask

    task automatic test_fill();
        logic [1:0] want [8] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00};
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            cycle(2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (obs_grant !== want[i]) begin
                n_errors++;
                $display("FAIL fill_grant[%0d]: got %b want %b", i, obs_grant, want[i]);
            end
        end
        n_checks++;
        if (obs_total !== 4'd6 || obs_iv !== 1'b0) begin
            n_errors++;
            $display("FAIL fill_total: total=%0d iv=%b want total=6 iv=0", obs_total, obs_iv);
        end
    endtask

    task automatic test_single_color();
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            cycle(2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (obs_grant !== ((i < 4) ? 2'b01 : 2'b00)) begin
                n_errors++;
                $display("FAIL single0_grant[%0d]: got %b want %b", i, obs_grant, (i < 4) ? 2'b01 : 2'b00);
            end
        end
        n_checks++;
        if (obs_total !== 4'd4) begin
            n_errors++;
            $display("FAIL single0_total: got %0d want 4", obs_total);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (obs_grant !== ((i < 2) ? 2'b10 : 2'b00)) begin
                n_errors++;
                $display("FAIL single1_grant[%0d]: got %b want %b", i, obs_grant, (i < 2) ? 2'b10 : 2'b00);
            end
        end
        n_checks++;
        if (obs_total !== 4'd6) begin
            n_errors++;
            $display("FAIL single1_total: got %0d want 6", obs_total);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        cycle(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (obs_grant !== 2'b01) begin
            n_errors++;
            $display("FAIL stall_first_grant: got %b want 01", obs_grant);
        end
        for (int i = 0; i < 5; i++) begin
            cycle(2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (obs_grant !== 2'b00 || obs_iv !== 1'b1 || obs_tag !== 1'b0 || obs_total !== 4'd1) begin
                n_errors++;
                $display("FAIL stall_hold[%0d]: grant=%b iv=%b tag=%b total=%0d want 00 1 0 1",
                         i, obs_grant, obs_iv, obs_tag, obs_total);
            end
        end
        cycle(2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (obs_grant !== 2'b10 || obs_iv !== 1'b1 || obs_tag !== 1'b1 || obs_total !== 4'd2) begin
            n_errors++;
            $display("FAIL stall_release: grant=%b iv=%b tag=%b total=%0d want 10 1 1 2",
                     obs_grant, obs_iv, obs_tag, obs_total);
        end
    endtask

    task automatic test_same_edge();
        apply_reset();
        for (int i = 0; i < 3; i++) cycle(2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
        // cnt0=3 (shared 1), cnt1=1
        cycle(2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (obs_grant !== 2'b01 || obs_total !== 4'd4) begin
            n_errors++;
            $display("FAIL same_tag_pushpop: grant=%b total=%0d want 01 4", obs_grant, obs_total);
        end
        cycle(2'b01, 1'b1, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (obs_grant !== 2'b01 || obs_total !== 4'd4) begin
            n_errors++;
            $display("FAIL cross_tag_pushpop: grant=%b total=%0d want 01 4", obs_grant, obs_total);
        end
        // cnt0=4 with shared pool full: colour 0 blocked, colour 1 still has reserve
        cycle(2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (obs_grant !== 2'b00) begin
            n_errors++;
            $display("FAIL shared_full_block: got %b want 00", obs_grant);
        end
        cycle(2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (obs_grant !== 2'b10 || obs_total !== 4'd5) begin
            n_errors++;
            $display("FAIL reserved_after_pop: grant=%b total=%0d want 10 5", obs_grant, obs_total);
        end
    endtask

    task automatic test_underflow();
        apply_reset();
        cycle(2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (obs_uf !== 1'b1 || obs_total !== 4'd0) begin
            n_errors++;
            $display("FAIL underflow_set: uf=%b total=%0d want 1 0", obs_uf, obs_total);
        end
        cycle(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (obs_uf !== 1'b1 || obs_iv !== 1'b1 || obs_total !== 4'd1) begin
            n_errors++;
            $display("FAIL underflow_sticky: uf=%b iv=%b total=%0d want 1 1 1", obs_uf, obs_iv, obs_total);
        end
        cycle(2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (obs_grant !== 2'b00 || obs_iv !== 1'b0 || obs_tag !== 1'b0 || obs_total !== 4'd0 || obs_uf !== 1'b0) begin
            n_errors++;
            $display("FAIL midstream_reset: grant=%b iv=%b tag=%b total=%0d uf=%b want all zero",
                     obs_grant, obs_iv, obs_tag, obs_total, obs_uf);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            cycle(2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), 1'b0);
            n_checks++;
            if (obs_grant !== exp_grant || obs_iv !== exp_iv || obs_total !== exp_total ||
                obs_uf !== exp_uf || (exp_iv && obs_tag !== exp_tag)) begin
                n_errors++;
                $display("FAIL random[%0d]: grant=%b/%b iv=%b/%b tag=%b/%b total=%0d/%0d uf=%b/%b (got/want)",
                         i, obs_grant, exp_grant, obs_iv, exp_iv, obs_tag, exp_tag,
                         obs_total, exp_total, obs_uf, exp_uf);
            end
            n_checks++;
            if (obs_total > 4'(MX)) begin
                n_errors++;
                $display("FAIL random_capacity[%0d]: total=%0d exceeds %0d", i, obs_total, MX);
            end
        end
    endtask

    initial begin
        rst = 1'b1; req = '0; issue_ready = 1'b1; ret_valid = 1'b0; ret_tag = '0;
        test_reset();
        test_fill();
        test_single_color();
        test_back_to_back();
        test_same_edge();
        test_underflow();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
